// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, fetch FSM states and the fetch-queue entry layout.
package mips32_pkg;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned WORD_W  = 32;

    // Register-register ALU group
    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b000010;
    localparam logic [OPC_W-1:0] OP_OR    = 6'b000011;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_MUL   = 6'b000101;
    // Memory, immediate and branch group
    localparam logic [OPC_W-1:0] OP_LW    = 6'b001000;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b001001;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001010;
    localparam logic [OPC_W-1:0] OP_SUBI  = 6'b001011;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_BNEQZ = 6'b001101;
    localparam logic [OPC_W-1:0] OP_BEQZ  = 6'b001110;
    localparam logic [OPC_W-1:0] OP_HLT   = 6'b111111;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // One prefetched instruction as handed to decode
    typedef struct packed {
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] npc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // True when the instruction word carries the HLT opcode
    function automatic logic is_hlt(input logic [WORD_W-1:0] ir);
        return ir[WORD_W-1 -: OPC_W] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_fifo_sync.sv
// Show-ahead synchronous FIFO with synchronous clear, occupancy count and full/empty flags.
module mips32_fifo_sync #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mips32_fifo_sync: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    // A push into a full FIFO is only honoured when the head leaves in the same cycle
    assign do_push_c = push && (!full || pop);
    assign do_pop_c  = pop && !empty;

    assign head_data = mem[rd_ptr];
    assign full      = count == CNT_W'(DEPTH);
    assign empty     = count == '0;

    // Storage array: data only, no reset needed
    always_ff @(posedge clk1) begin
        if (do_push_c && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and count; clear wins over push/pop
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: PC, one-deep in-flight tracking, prefetch queue, HLT/redirect FSM.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall_fetch,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    input  logic              if_id_ready,
    output logic [31:0]       if_id_ir,
    output logic [31:0]       if_id_npc,
    output logic              fetch_halted,
    output logic [CNT_W-1:0]  occupancy
);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   inflight_addr;
    logic                inflight;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;

    logic [CNT_W:0]      credit_used_c;
    logic                issue_c;
    logic                push_c;
    logic                pop_c;
    fetch_entry_t        push_entry_c;
    fetch_entry_t        head_entry_c;
    logic                unused_redirect_hi;

    assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];

    // Credit check counts queued entries plus the outstanding read; a same-cycle pop is ignored
    assign credit_used_c = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
    assign issue_c = rst_n && (state == FETCH) && !stall_fetch && !redirect_valid
                   && (credit_used_c < (CNT_W + 1)'(DEPTH));

    // Returning read is kept unless squashed by a redirect or fetch has already halted
    assign push_c = inflight && !redirect_valid && (state == FETCH);
    assign pop_c  = if_id_valid && if_id_ready;

    assign push_entry_c = '{ir: imem_rdata, npc: 32'(inflight_addr) + 32'd1};
    assign head_entry_c = fetch_entry_t'(fifo_head);

    assign imem_req     = issue_c;
    assign imem_addr    = pc;
    assign if_id_valid  = !fifo_empty;
    assign if_id_ir     = if_id_valid ? head_entry_c.ir  : '0;
    assign if_id_npc    = if_id_valid ? head_entry_c.npc : '0;
    assign fetch_halted = state == HALTED;
    assign occupancy    = fifo_count;

    mips32_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clr       (redirect_valid),
        .push      (push_c),
        .push_data (push_entry_c),
        .pop       (pop_c),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // PC, in-flight read tracking and fetch/halt FSM; redirect has top priority
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= ADDR_W'(RESET_PC);
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (redirect_valid) begin
            state    <= FETCH;
            pc       <= redirect_pc[ADDR_W-1:0];
            inflight <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                pc            <= pc + ADDR_W'(1);
                inflight_addr <= pc;
            end
            if (push_c && is_hlt(imem_rdata)) begin
                state <= HALTED;
            end
        end
    end

    // The credit rule must always leave room for the returning word
    a_no_push_when_full: assert property (
        @(posedge clk1) disable iff (!rst_n) !(push_c && fifo_full)
    );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for the fetch queue: streaming, back-pressure, redirect, HLT, PC wrap, async reset.
module tb_mips32_fetch_queue;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              stall_fetch;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              if_id_valid;
    logic              if_id_ready;
    logic [31:0]       if_id_ir;
    logic [31:0]       if_id_npc;
    logic              fetch_halted;
    logic [CNT_W-1:0]  occupancy;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk1 = ~clk1;

    // 1-cycle-latency synchronous instruction memory
    always @(posedge clk1) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    mips32_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_fetch    (stall_fetch),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_ready    (if_id_ready),
        .if_id_ir       (if_id_ir),
        .if_id_npc      (if_id_npc),
        .fetch_halted   (fetch_halted),
        .occupancy      (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk1);
    endtask

    initial begin
        // ADD-opcode words whose value equals their address, plus one HLT at 0x45
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'(i);
        mem[16'h45] = 32'hFC00_0045;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall_fetch    = 1'b0;
        if_id_ready    = 1'b1;

        // Reset state
        #3;
        check("rst_req",    32'(imem_req),     32'd0);
        check("rst_valid",  32'(if_id_valid),  32'd0);
        check("rst_ir",     if_id_ir,          32'd0);
        check("rst_npc",    if_id_npc,         32'd0);
        check("rst_halted", 32'(fetch_halted), 32'd0);
        check("rst_occ",    32'(occupancy),    32'd0);

        // Streaming from RESET_PC with decode always ready
        tick(); rst_n = 1'b1; #1;
        check("first_req",  32'(imem_req),  32'd1);
        check("first_addr", 32'(imem_addr), 32'd0);
        check("first_valid", 32'(if_id_valid), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(); #1;
            check("seq_req",  32'(imem_req),  32'd1);
            check("seq_addr", 32'(imem_addr), 32'(k));
            if (k == 1) begin
                check("seq_valid_lat", 32'(if_id_valid), 32'd0);
            end else begin
                check("seq_valid", 32'(if_id_valid), 32'd1);
                check("seq_ir",    if_id_ir,         32'(k - 2));
                check("seq_npc",   if_id_npc,        32'(k - 1));
                check("seq_occ",   32'(occupancy),   32'd1);
            end
        end

        // Decode stalled for 10 cycles: queue fills to DEPTH, requests stop
        for (int k = 7; k <= 16; k++) begin
            tick();
            if (k == 7) if_id_ready = 1'b0;
            #1;
            check("bp_ir",  if_id_ir,        32'd5);
            check("bp_occ", 32'(occupancy),  (k - 6 > 4) ? 32'd4 : 32'(k - 6));
            check("bp_req", 32'(imem_req),   (k < 9) ? 32'd1 : 32'd0);
        end

        // Release: entries drain in order, no gaps
        for (int k = 17; k <= 22; k++) begin
            tick();
            if (k == 17) if_id_ready = 1'b1;
            #1;
            check("rel_valid", 32'(if_id_valid), 32'd1);
            check("rel_ir",    if_id_ir,         32'(k - 12));
            check("rel_npc",   if_id_npc,        32'(k - 11));
        end

        // Redirect to 0x20 with 3 queued and one read in flight
        tick(); if_id_ready = 1'b0; #1;
        check("pre_redir_occ",  32'(occupancy), 32'd2);
        check("pre_redir_addr", 32'(imem_addr), 32'd14);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
        check("redir_occ3", 32'(occupancy), 32'd3);
        check("redir_req",  32'(imem_req),  32'd0);
        tick(); redirect_valid = 1'b0; if_id_ready = 1'b1; #1;
        check("redir_flush_valid", 32'(if_id_valid), 32'd0);
        check("redir_flush_occ",   32'(occupancy),   32'd0);
        check("redir_req1",        32'(imem_req),    32'd1);
        check("redir_addr1",       32'(imem_addr),   32'h20);
        tick(); #1;
        check("redir_stale_drop", 32'(occupancy), 32'd0);
        check("redir_addr2",      32'(imem_addr), 32'h21);
        tick(); #1;
        check("redir_valid", 32'(if_id_valid), 32'd1);
        check("redir_ir",    if_id_ir,         32'h20);
        check("redir_npc",   if_id_npc,        32'h21);
        tick(); #1;
        check("redir_ir2", if_id_ir, 32'h21);

        // HLT at 0x45: entries through the HLT delivered, then fetch stops
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        check("hlt_pre_ir", if_id_ir, 32'h22);
        for (int j = 0; j <= 6; j++) begin
            tick();
            if (j == 0) redirect_valid = 1'b0;
            #1;
            check("hlt_req",    32'(imem_req),     32'd1);
            check("hlt_addr",   32'(imem_addr),    32'(32'h40 + j));
            check("hlt_halted", 32'(fetch_halted), 32'd0);
            if (j >= 2) check("hlt_ir", if_id_ir, 32'(32'h40 + j - 2));
        end
        tick(); #1;
        check("hlt_halted1", 32'(fetch_halted), 32'd1);
        check("hlt_req0",    32'(imem_req),     32'd0);
        check("hlt_head",    if_id_ir,          32'hFC00_0045);
        check("hlt_npc",     if_id_npc,         32'h46);
        for (int j = 0; j < 3; j++) begin
            tick(); #1;
            check("halt_valid", 32'(if_id_valid),  32'd0);
            check("halt_occ",   32'(occupancy),    32'd0);
            check("halt_req",   32'(imem_req),     32'd0);
            check("halt_flag",  32'(fetch_halted), 32'd1);
        end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
        check("resume_redir_halted", 32'(fetch_halted), 32'd1);
        tick(); redirect_valid = 1'b0; #1;
        check("resume_halted", 32'(fetch_halted), 32'd0);
        check("resume_req",    32'(imem_req),     32'd1);
        check("resume_addr",   32'(imem_addr),    32'h10);
        tick(); #1;
        check("resume_addr2", 32'(imem_addr), 32'h11);
        tick(); #1;
        check("resume_ir",  if_id_ir,  32'h10);
        check("resume_npc", if_id_npc, 32'h11);

        // PC wrap: upper redirect bits ignored, 1023 -> 0, npc unwrapped
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        tick(); redirect_valid = 1'b0; #1;
        check("wrap_addr_top", 32'(imem_addr), 32'h3FF);
        tick(); #1;
        check("wrap_addr_zero", 32'(imem_addr), 32'd0);
        tick(); #1;
        check("wrap_ir",  if_id_ir,  32'h3FF);
        check("wrap_npc", if_id_npc, 32'h400);
        tick(); #1;
        check("wrap_ir0",  if_id_ir,  32'd0);
        check("wrap_npc0", if_id_npc, 32'd1);

        // Asynchronous reset with a full queue
        tick(); if_id_ready = 1'b0; #1;
        for (int j = 0; j < 4; j++) begin
            tick(); #1;
        end
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_req", 32'(imem_req),  32'd0);
        tick(); rst_n = 1'b0; #1;
        check("arst_valid", 32'(if_id_valid), 32'd0);
        check("arst_occ",   32'(occupancy),   32'd0);
        check("arst_req",   32'(imem_req),    32'd0);
        check("arst_ir",    if_id_ir,         32'd0);
        tick(); rst_n = 1'b1; if_id_ready = 1'b1; #1;
        check("arst_req1",  32'(imem_req),    32'd1);
        check("arst_addr0", 32'(imem_addr),   32'd0);
        check("arst_valid0", 32'(if_id_valid), 32'd0);
        tick(); #1;
        check("arst_addr1", 32'(imem_addr), 32'd1);
        tick(); #1;
        check("arst_head_valid", 32'(if_id_valid), 32'd1);
        check("arst_head_ir",    if_id_ir,         32'd0);
        check("arst_head_npc",   if_id_npc,        32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
